// File: rtl/ahb_mtx_decoder_multi.sv
// AHB bus-matrix input-stage decoder.
// Decodes each address phase onto one of NUM_PORTS output stages or onto an
// internal default slave, remembers the data-phase owner to steer the response
// path back, and counts default-slave ERROR responses for diagnostics.
module ahb_mtx_decoder_multi #(
  parameter int unsigned                NUM_PORTS    = 4,
  parameter int unsigned                DATA_W       = 32,
  parameter logic [22*NUM_PORTS-1:0]    REGION_BASE  = {NUM_PORTS{22'h0}},
  parameter logic [22*NUM_PORTS-1:0]    REGION_LIMIT = {NUM_PORTS{22'h3f}},
  parameter int unsigned                ERR_CNT_W    = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          HREADYS,
  input  logic                          sel_dec,
  input  logic [21:0]                   decode_addr_dec,
  input  logic [1:0]                    trans_dec,
  input  logic [NUM_PORTS-1:0]          region_en,
  input  logic                          err_clr,
  input  logic [NUM_PORTS-1:0]          active_dec_in,
  input  logic [NUM_PORTS-1:0]          readyout_dec,
  input  logic [2*NUM_PORTS-1:0]        resp_dec,
  input  logic [DATA_W*NUM_PORTS-1:0]   rdata_dec,
  input  logic [DATA_W*NUM_PORTS-1:0]   ruser_dec,
  output logic [NUM_PORTS-1:0]          sel_dec_out,
  output logic                          active_dec,
  output logic                          HREADYOUTS,
  output logic [1:0]                    HRESPS,
  output logic [DATA_W-1:0]             HRDATAS,
  output logic [DATA_W-1:0]             HRUSERS,
  output logic [ERR_CNT_W-1:0]          err_count
);

  // Owner index: 0..NUM_PORTS-1 are output stages, NUM_PORTS is the default slave.
  localparam int unsigned      OWN_W      = $clog2(NUM_PORTS + 1);
  localparam logic [OWN_W-1:0] OWN_DS     = OWN_W'(NUM_PORTS);
  localparam logic [1:0]       TRANS_IDLE = 2'b00;
  localparam logic [1:0]       RESP_OKAY  = 2'b00;
  localparam logic [1:0]       RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t              ds_state_q, ds_state_d;
  logic [OWN_W-1:0]       data_owner_q, data_owner_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [OWN_W-1:0]       match_owner;
  logic                   match_found;
  logic [OWN_W-1:0]       addr_owner;
  logic                   ds_qual;
  logic                   ds_ready;
  logic [1:0]             ds_resp;

  // Region match: lowest enabled region containing the address wins; inverted ranges never match.
  always_comb begin
    match_owner = OWN_DS;
    match_found = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!match_found && region_en[p] &&
          (decode_addr_dec >= REGION_BASE[22*p +: 22]) &&
          (decode_addr_dec <= REGION_LIMIT[22*p +: 22])) begin
        match_owner = OWN_W'(p);
        match_found = 1'b1;
      end
    end
    // IDLE transfers stay with the data-phase owner so the select never toggles on idle.
    addr_owner = (trans_dec == TRANS_IDLE) ? data_owner_q : match_owner;
  end

  // Address-phase select and active flag of the addressed stage.
  always_comb begin
    sel_dec_out = '0;
    active_dec  = 1'b1;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (addr_owner == OWN_W'(p)) begin
        sel_dec_out[p] = sel_dec;
        active_dec     = active_dec_in[p];
      end
    end
  end

  // Default-slave FSM next state and response: two-cycle ERROR for NONSEQ/SEQ.
  always_comb begin
    ds_qual    = (addr_owner == OWN_DS) && sel_dec && HREADYS && trans_dec[1];
    ds_state_d = ds_state_q;
    ds_ready   = 1'b1;
    ds_resp    = RESP_OKAY;
    case (ds_state_q)
      DS_IDLE: begin
        if (ds_qual) ds_state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_ready   = 1'b0;
        ds_resp    = RESP_ERROR;
        ds_state_d = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp    = RESP_ERROR;
        ds_state_d = ds_qual ? DS_ERR1 : DS_IDLE;
      end
      default: ds_state_d = DS_IDLE;
    endcase
  end

  // Data-owner tracking and saturating error counter (clear has priority).
  always_comb begin
    data_owner_d = HREADYS ? addr_owner : data_owner_q;
    err_count_d  = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if ((ds_state_d == DS_ERR1) && (ds_state_q != DS_ERR1) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_state_q   <= DS_IDLE;
      data_owner_q <= OWN_DS;
      err_count_q  <= '0;
    end else begin
      ds_state_q   <= ds_state_d;
      data_owner_q <= data_owner_d;
      err_count_q  <= err_count_d;
    end
  end

  // Data-phase response mux driven by the data-phase owner.
  always_comb begin
    HREADYOUTS = ds_ready;
    HRESPS     = ds_resp;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (data_owner_q == OWN_W'(p)) begin
        HREADYOUTS = readyout_dec[p];
        HRESPS     = resp_dec[2*p +: 2];
        HRDATAS    = rdata_dec[DATA_W*p +: DATA_W];
        HRUSERS    = ruser_dec[DATA_W*p +: DATA_W];
      end
    end
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_ahb_mtx_decoder_multi.sv
// Scoreboard bench for ahb_mtx_decoder_multi: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_ahb_mtx_decoder_multi;

  localparam int NP = 4;
  localparam int DS = NP;
  localparam logic [22*NP-1:0] RB = {22'h300, 22'h100, 22'h020, 22'h000};
  localparam logic [22*NP-1:0] RL = {22'h2ff, 22'h1ff, 22'h07f, 22'h03f};

  int unsigned base_a[NP]  = '{32'h000, 32'h020, 32'h100, 32'h300};
  int unsigned limit_a[NP] = '{32'h03f, 32'h07f, 32'h1ff, 32'h2ff};

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HREADYS;
  logic              sel_dec;
  logic [21:0]       decode_addr_dec;
  logic [1:0]        trans_dec;
  logic [NP-1:0]     region_en;
  logic              err_clr;
  logic [NP-1:0]     active_dec_in;
  logic [NP-1:0]     readyout_dec;
  logic [2*NP-1:0]   resp_dec;
  logic [32*NP-1:0]  rdata_dec;
  logic [32*NP-1:0]  ruser_dec;
  logic [NP-1:0]     sel_dec_out, sel_dec_out_s;
  logic              active_dec, active_dec_s;
  logic              HREADYOUTS, HREADYOUTS_s;
  logic [1:0]        HRESPS, HRESPS_s;
  logic [31:0]       HRDATAS, HRDATAS_s, HRUSERS, HRUSERS_s;
  logic [7:0]        err_count;
  logic [1:0]        err_count_s;

  ahb_mtx_decoder_multi #(
    .NUM_PORTS(NP), .DATA_W(32), .REGION_BASE(RB), .REGION_LIMIT(RL), .ERR_CNT_W(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .region_en(region_en),
    .err_clr(err_clr), .active_dec_in(active_dec_in), .readyout_dec(readyout_dec),
    .resp_dec(resp_dec), .rdata_dec(rdata_dec), .ruser_dec(ruser_dec),
    .sel_dec_out(sel_dec_out), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS), .err_count(err_count)
  );

  // Narrow-counter instance to exercise saturation quickly.
  ahb_mtx_decoder_multi #(
    .NUM_PORTS(NP), .DATA_W(32), .REGION_BASE(RB), .REGION_LIMIT(RL), .ERR_CNT_W(2)
  ) dut_sat (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .region_en(region_en),
    .err_clr(err_clr), .active_dec_in(active_dec_in), .readyout_dec(readyout_dec),
    .resp_dec(resp_dec), .rdata_dec(rdata_dec), .ruser_dec(ruser_dec),
    .sel_dec_out(sel_dec_out_s), .active_dec(active_dec_s), .HREADYOUTS(HREADYOUTS_s),
    .HRESPS(HRESPS_s), .HRDATAS(HRDATAS_s), .HRUSERS(HRUSERS_s), .err_count(err_count_s)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [NP-1:0] sel;
    logic          act;
    logic          rdy;
    logic [1:0]    resp;
    logic [31:0]   rdata;
    logic [31:0]   ruser;
    logic [7:0]    cnt;
    logic [1:0]    cnt_sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;

  // Reference model state: data-phase owner, cycle index within a DS error response
  // (0 none, 1 first wait cycle, 2 final cycle), and error tallies.
  int m_owner = DS;
  int m_phase = 0;
  int m_cnt   = 0;
  int m_cnt_s = 0;

  // Staged stimulus, applied just after each rising edge.
  logic          st_rstn, st_clr;
  logic [NP-1:0] st_en, st_act, st_rdy;
  logic [2*NP-1:0] st_resp;
  logic [31:0]   st_rdata[NP];
  logic [31:0]   st_ruser[NP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode_ref(input logic [21:0] a, input logic [NP-1:0] en);
    int unsigned av;
    av = 32'(a);
    for (int i = 0; i < NP; i++)
      if (en[i] && av >= base_a[i] && av <= limit_a[i]) return i;
    return DS;
  endfunction

  // Apply one cycle of stimulus, predict the outputs for this cycle and advance the model.
  task automatic drive(input logic s, input logic [21:0] a, input logic [1:0] t, input logic hr);
    exp_t e;
    int ao;
    int nphase;
    bit qual;
    @(posedge HCLK);
    #1;
    HRESETn = st_rstn; sel_dec = s; decode_addr_dec = a; trans_dec = t; HREADYS = hr;
    region_en = st_en; err_clr = st_clr; active_dec_in = st_act; readyout_dec = st_rdy;
    resp_dec = st_resp;
    for (int i = 0; i < NP; i++) begin
      rdata_dec[32*i +: 32] = st_rdata[i];
      ruser_dec[32*i +: 32] = st_ruser[i];
    end
    if (!st_rstn) begin
      m_owner = DS; m_phase = 0; m_cnt = 0; m_cnt_s = 0;
    end
    ao      = (t == 2'b00) ? m_owner : decode_ref(a, st_en);
    e.sel   = (s && ao < NP) ? NP'(1 << ao) : '0;
    e.act   = (ao == DS) ? 1'b1 : st_act[ao];
    if (m_owner == DS) begin
      e.rdy   = (m_phase != 1);
      e.resp  = (m_phase != 0) ? 2'b01 : 2'b00;
      e.rdata = '0;
      e.ruser = '0;
    end else begin
      e.rdy   = st_rdy[m_owner];
      e.resp  = st_resp[2*m_owner +: 2];
      e.rdata = st_rdata[m_owner];
      e.ruser = st_ruser[m_owner];
    end
    e.cnt     = 8'(m_cnt);
    e.cnt_sat = 2'(m_cnt_s);
    exp_q.push_back(e);
    if (st_rstn) begin
      qual   = (ao == DS) && s && hr && t[1];
      nphase = (m_phase == 1) ? 2 : (qual ? 1 : 0);
      if (st_clr) begin
        m_cnt = 0; m_cnt_s = 0;
      end else if (nphase == 1) begin
        m_cnt   = (m_cnt   < 255) ? m_cnt + 1   : 255;
        m_cnt_s = (m_cnt_s < 3)   ? m_cnt_s + 1 : 3;
      end
      if (hr) m_owner = ao;
      m_phase = nphase;
    end
  endtask

  // Monitor: compare every presented cycle against the next scoreboard entry.
  always @(negedge HCLK) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sel_dec_out",   32'(sel_dec_out), 32'(mon_e.sel));
      check("active_dec",    32'(active_dec),  32'(mon_e.act));
      check("HREADYOUTS",    32'(HREADYOUTS),  32'(mon_e.rdy));
      check("HRESPS",        32'(HRESPS),      32'(mon_e.resp));
      check("HRDATAS",       HRDATAS,          mon_e.rdata);
      check("HRUSERS",       HRUSERS,          mon_e.ruser);
      check("err_count",     32'(err_count),   32'(mon_e.cnt));
      check("err_count_sat", 32'(err_count_s), 32'(mon_e.cnt_sat));
    end
  end

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [21:0] UNMAPPED = 22'h200000;

  function automatic logic [21:0] pick_addr();
    int unsigned j, k, lo, hi;
    j = $urandom_range(0, NP - 1);
    k = $urandom_range(0, 9);
    lo = base_a[j];
    hi = limit_a[j];
    case (k)
      0: return 22'(lo);
      1: return 22'(hi);
      2: return 22'(hi + 1);
      3: return 22'(lo - 1);
      4, 5, 6: return (lo <= hi) ? 22'($urandom_range(hi, lo)) : 22'(lo);
      7: return 22'($urandom);
      8: return UNMAPPED;
      default: return 22'($urandom_range(32'h3ff, 0));
    endcase
  endfunction

  initial begin
    int wait_cnt;
    HRESETn = 1'b0; HREADYS = 1'b1; sel_dec = 1'b0; decode_addr_dec = '0; trans_dec = IDLE;
    region_en = '0; err_clr = 1'b0; active_dec_in = '0; readyout_dec = '1; resp_dec = '0;
    rdata_dec = '0; ruser_dec = '0;
    st_rstn = 1'b0; st_clr = 1'b0; st_en = 4'b0001; st_act = 4'b1010; st_rdy = '1; st_resp = '0;
    for (int i = 0; i < NP; i++) begin
      st_rdata[i] = 32'h1000_0000 * (i + 1);
      st_ruser[i] = 32'h0000_0100 * (i + 1);
    end
    st_rdata[0] = 32'hDEADBEEF;

    // Reset state with sel_dec low.
    drive(1'b0, 22'h0, IDLE, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b1);
    st_rstn = 1'b1;

    // NONSEQ into port 0, then read data appears from port 0.
    drive(1'b1, 22'h1, NONSEQ, 1'b1);
    drive(1'b1, 22'h1, IDLE, 1'b1);

    // Unmapped NONSEQ: two-cycle error then OKAY.
    drive(1'b1, UNMAPPED, NONSEQ, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b0);
    drive(1'b0, 22'h0, IDLE, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b1);

    // Port 0 stalls while the next address goes to port 1.
    st_en = 4'b0011;
    drive(1'b1, 22'h10, NONSEQ, 1'b1);
    st_rdy = 4'b1110; st_resp = 8'b00_00_00_10;
    for (int i = 0; i < 3; i++) drive(1'b1, 22'h50, NONSEQ, 1'b0);
    st_rdy = 4'b1111; st_resp = '0;
    drive(1'b1, 22'h50, NONSEQ, 1'b1);
    drive(1'b1, 22'h50, IDLE, 1'b1);

    // Back-to-back unmapped NONSEQs: ERR2 straight into ERR1, saturates narrow counter.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, UNMAPPED, NONSEQ, 1'b1);
      drive(1'b1, UNMAPPED, NONSEQ, 1'b0);
    end
    drive(1'b0, 22'h0, IDLE, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b1);

    // Disabled region decodes as unmapped; overlap priority with region 0 disabled.
    st_en = 4'b1110;
    drive(1'b1, 22'h1, NONSEQ, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b0);
    drive(1'b1, 22'h30, SEQ, 1'b1);
    st_en = 4'b1111;
    drive(1'b1, 22'h30, NONSEQ, 1'b1);
    drive(1'b1, 22'h300, NONSEQ, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b1);
    drive(1'b0, 22'h0, IDLE, 1'b1);

    // Clear coinciding with ERR1 entry.
    st_clr = 1'b1;
    drive(1'b1, UNMAPPED, NONSEQ, 1'b1);
    st_clr = 1'b0;
    drive(1'b0, 22'h0, IDLE, 1'b0);
    drive(1'b0, 22'h0, IDLE, 1'b1);

    // Reset asserted in the first error cycle.
    drive(1'b1, UNMAPPED, NONSEQ, 1'b1);
    st_rstn = 1'b0;
    drive(1'b0, 22'h0, IDLE, 1'b0);
    st_rstn = 1'b1;
    drive(1'b0, 22'h0, IDLE, 1'b1);

    // IDLE and BUSY to the default slave are zero-wait OKAY.
    drive(1'b1, UNMAPPED, BUSY, 1'b1);
    drive(1'b1, UNMAPPED, IDLE, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) st_en = NP'($urandom);
      st_clr  = ($urandom_range(0, 31) == 0);
      st_rstn = ($urandom_range(0, 599) != 0);
      st_act  = NP'($urandom);
      st_rdy  = NP'($urandom) | NP'($urandom);
      st_resp = (2*NP)'($urandom);
      for (int i = 0; i < NP; i++) begin
        st_rdata[i] = $urandom;
        st_ruser[i] = $urandom;
      end
      drive($urandom_range(0, 7) != 0, pick_addr(), 2'($urandom), $urandom_range(0, 3) != 0);
    end
    st_rstn = 1'b1;
    st_clr  = 1'b0;

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge HCLK);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
